// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: global stall/flush arbitration for the in-order pipe; PIPE_HAZARD_CTL_PERF_EN enables hazard counters
module pipe_hazard_ctl #(
   parameter int NUM_STAGES    = 5,
   parameter int REDIRECT_STAGE = 2,
   parameter int LOADUSE_STAGE = 2,
   parameter int MC_STAGE      = 2,
   parameter int MC_CYC_W      = 6,
   parameter int RST_FLUSH_CYC = 2,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_busy,
   input  logic                  redirect_req,
   input  logic                  lw_hazard,
   input  logic                  mc_start,
   input  logic [MC_CYC_W-1:0]   mc_cycles,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush,
   output logic                  mc_busy,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      redirect_cnt
);
   localparam int FLUSH_W = $clog2(RST_FLUSH_CYC + 1);
   localparam int CW = (MC_CYC_W > FLUSH_W) ? MC_CYC_W : FLUSH_W;
   localparam logic [NUM_STAGES-1:0] ALL = '1;
   localparam logic [NUM_STAGES-1:0] MC_STALL = ALL >> (NUM_STAGES - 1 - MC_STAGE);
   localparam logic [NUM_STAGES-1:0] MC_FLUSH = NUM_STAGES'(1) << (MC_STAGE + 1);
   localparam logic [NUM_STAGES-1:0] RD_FLUSH = (ALL >> (NUM_STAGES - REDIRECT_STAGE + 1)) << 1;
   localparam logic [NUM_STAGES-1:0] LW_STALL = ALL >> (NUM_STAGES - LOADUSE_STAGE);
   localparam logic [NUM_STAGES-1:0] LW_FLUSH = NUM_STAGES'(1) << LOADUSE_STAGE;

   typedef enum logic [1:0] {RST_FLUSH, RUN, MC_WAIT} stateT;

   stateT         state;
   logic [CW-1:0] cnt;
   logic          mcGo;

   assign mcGo = state == RUN && mc_start && mc_cycles != '0;

   // priority arbitration of the hazard sources into per-stage stall/flush
   always_comb begin
      stall   = '0;
      flush   = '0;
      mc_busy = 1'b0;
      if (state == RST_FLUSH) flush = ALL;
      else if (mem_busy) begin
         stall   = ALL;
         mc_busy = state == MC_WAIT;
      end else if (state == MC_WAIT || mcGo) begin
         stall   = MC_STALL;
         flush   = MC_FLUSH;
         mc_busy = 1'b1;
      end else if (redirect_req) flush = RD_FLUSH;
      else if (lw_hazard) begin
         stall = LW_STALL;
         flush = LW_FLUSH;
      end
   end

   // post-reset flush sequencing and multicycle occupancy tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RST_FLUSH;
         cnt   <= CW'(RST_FLUSH_CYC);
      end else begin
         case (state)
            RST_FLUSH: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= RUN;
            end
            RUN: if (!mem_busy && mcGo && mc_cycles != MC_CYC_W'(1)) begin
               cnt   <= CW'(mc_cycles - 1'b1);
               state <= MC_WAIT;
            end
            default: if (!mem_busy) begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= RUN;
            end
         endcase
      end
   end

`ifdef PIPE_HAZARD_CTL_PERF_EN
   logic redirectTake;

   assign redirectTake = state == RUN && !mem_busy && !mcGo && redirect_req;

   // saturating hazard performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (stall[0] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (redirectTake && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt    = '0;
   assign redirect_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: directed self-checking bench for pipe_hazard_ctl (CNT_W=4 to reach saturation)
module tb_pipe_hazard_ctl;
`ifdef PIPE_HAZARD_CTL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mem_busy = 1'b0;
   logic       redirect_req = 1'b0;
   logic       lw_hazard = 1'b0;
   logic       mc_start = 1'b0;
   logic [5:0] mc_cycles = '0;
   logic [4:0] stall, flush;
   logic       mc_busy;
   logic [3:0] stall_cnt, redirect_cnt;
   int checks = 0;
   int failures = 0;
   int scModel = 0;
   int rcModel = 0;

   pipe_hazard_ctl #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .mem_busy(mem_busy), .redirect_req(redirect_req),
      .lw_hazard(lw_hazard), .mc_start(mc_start), .mc_cycles(mc_cycles),
      .stall(stall), .flush(flush), .mc_busy(mc_busy),
      .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] expSc();
      return PERF ? ((scModel > 15) ? 4'd15 : 4'(scModel)) : 4'd0;
   endfunction

   function automatic logic [3:0] expRc();
      return PERF ? ((rcModel > 15) ? 4'd15 : 4'(rcModel)) : 4'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (flush !== 5'b11111 || stall !== 5'b0 || mc_busy !== 1'b0) begin failures++; $display("FAIL reset_out flush=%b stall=%b busy=%b exp 11111/00000/0", flush, stall, mc_busy); end
      checks++; if (stall_cnt !== 4'd0 || redirect_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt sc=%0d rc=%0d exp 0/0", stall_cnt, redirect_cnt); end
      tick();
      reset = 1'b1;
      mem_busy = 1'b1;
      lw_hazard = 1'b1;
      #1;
      checks++; if (flush !== 5'b11111 || stall !== 5'b0) begin failures++; $display("FAIL flush_cyc1 flush=%b stall=%b exp 11111/00000", flush, stall); end
      tick();
      checks++; if (flush !== 5'b11111 || stall !== 5'b0) begin failures++; $display("FAIL flush_cyc2 flush=%b stall=%b exp 11111/00000", flush, stall); end
      tick();
      mem_busy = 1'b0;
      lw_hazard = 1'b0;
      #1;
      checks++; if (flush !== 5'b0 || stall !== 5'b0) begin failures++; $display("FAIL post_flush flush=%b stall=%b exp 00000/00000", flush, stall); end
      checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL flush_no_count sc=%0d exp 0", stall_cnt); end
   endtask

   task automatic test_lw();
      lw_hazard = 1'b1;
      #1;
      checks++; if (stall !== 5'b00011 || flush !== 5'b00100) begin failures++; $display("FAIL lw stall=%b flush=%b exp 00011/00100", stall, flush); end
      tick();
      scModel++;
      lw_hazard = 1'b0;
      #1;
      checks++; if (stall !== 5'b0 || flush !== 5'b0) begin failures++; $display("FAIL lw_clear stall=%b flush=%b exp 0/0", stall, flush); end
      checks++; if (stall_cnt !== expSc()) begin failures++; $display("FAIL lw_sc sc=%0d exp %0d", stall_cnt, expSc()); end
   endtask

   task automatic test_redirect();
      redirect_req = 1'b1;
      lw_hazard = 1'b1;
      #1;
      checks++; if (stall !== 5'b0 || flush !== 5'b00010) begin failures++; $display("FAIL redir stall=%b flush=%b exp 00000/00010", stall, flush); end
      tick();
      rcModel++;
      redirect_req = 1'b0;
      lw_hazard = 1'b0;
      #1;
      checks++; if (redirect_cnt !== expRc()) begin failures++; $display("FAIL redir_cnt rc=%0d exp %0d", redirect_cnt, expRc()); end
   endtask

   task automatic test_mc();
      mc_start = 1'b1;
      mc_cycles = 6'd4;
      #1;
      checks++; if (stall !== 5'b00111 || flush !== 5'b01000 || mc_busy !== 1'b1) begin failures++; $display("FAIL mc_c1 stall=%b flush=%b busy=%b exp 00111/01000/1", stall, flush, mc_busy); end
      tick();
      mc_start = 1'b1;
      redirect_req = 1'b1;
      lw_hazard = 1'b1;
      #1;
      checks++; if (stall !== 5'b00111 || flush !== 5'b01000 || mc_busy !== 1'b1) begin failures++; $display("FAIL mc_c2 stall=%b flush=%b busy=%b exp 00111/01000/1", stall, flush, mc_busy); end
      tick();
      mc_start = 1'b0;
      lw_hazard = 1'b0;
      mem_busy = 1'b1;
      #1;
      checks++; if (stall !== 5'b11111 || flush !== 5'b0 || mc_busy !== 1'b1) begin failures++; $display("FAIL mc_mem stall=%b flush=%b busy=%b exp 11111/00000/1", stall, flush, mc_busy); end
      tick();
      mem_busy = 1'b0;
      #1;
      checks++; if (stall !== 5'b00111 || flush !== 5'b01000 || mc_busy !== 1'b1) begin failures++; $display("FAIL mc_c4 stall=%b flush=%b busy=%b exp 00111/01000/1", stall, flush, mc_busy); end
      tick();
      checks++; if (stall !== 5'b00111 || flush !== 5'b01000 || mc_busy !== 1'b1) begin failures++; $display("FAIL mc_c5 stall=%b flush=%b busy=%b exp 00111/01000/1", stall, flush, mc_busy); end
      tick();
      scModel += 5;
      checks++; if (stall !== 5'b0 || flush !== 5'b00010 || mc_busy !== 1'b0) begin failures++; $display("FAIL mc_run_redir stall=%b flush=%b busy=%b exp 00000/00010/0", stall, flush, mc_busy); end
      tick();
      rcModel++;
      redirect_req = 1'b0;
      #1;
      checks++; if (stall_cnt !== expSc() || redirect_cnt !== expRc()) begin failures++; $display("FAIL mc_cnt sc=%0d rc=%0d exp %0d/%0d", stall_cnt, redirect_cnt, expSc(), expRc()); end
   endtask

   task automatic test_mc_short();
      mc_start = 1'b1;
      mc_cycles = 6'd0;
      #1;
      checks++; if (stall !== 5'b0 || flush !== 5'b0 || mc_busy !== 1'b0) begin failures++; $display("FAIL mc_zero stall=%b flush=%b busy=%b exp 0/0/0", stall, flush, mc_busy); end
      tick();
      mc_cycles = 6'd1;
      #1;
      checks++; if (stall !== 5'b00111 || mc_busy !== 1'b1) begin failures++; $display("FAIL mc_one stall=%b busy=%b exp 00111/1", stall, mc_busy); end
      tick();
      scModel++;
      mc_start = 1'b0;
      #1;
      checks++; if (stall !== 5'b0 || mc_busy !== 1'b0) begin failures++; $display("FAIL mc_one_done stall=%b busy=%b exp 0/0", stall, mc_busy); end
   endtask

   task automatic test_reset_mid_mc();
      mc_start = 1'b1;
      mc_cycles = 6'd4;
      tick();
      mc_start = 1'b0;
      #1;
      checks++; if (mc_busy !== 1'b1) begin failures++; $display("FAIL mid_mc_busy busy=%b exp 1", mc_busy); end
      reset = 1'b0;
      scModel = 0;
      rcModel = 0;
      #1;
      checks++; if (flush !== 5'b11111 || stall !== 5'b0 || mc_busy !== 1'b0) begin failures++; $display("FAIL mid_rst flush=%b stall=%b busy=%b exp 11111/00000/0", flush, stall, mc_busy); end
      checks++; if (stall_cnt !== 4'd0 || redirect_cnt !== 4'd0) begin failures++; $display("FAIL mid_rst_cnt sc=%0d rc=%0d exp 0/0", stall_cnt, redirect_cnt); end
      tick();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (flush !== 5'b0 || stall !== 5'b0) begin failures++; $display("FAIL mid_rst_run flush=%b stall=%b exp 0/0", flush, stall); end
   endtask

   task automatic test_saturate();
      mem_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++; if (stall !== 5'b11111 || flush !== 5'b0) begin failures++; $display("FAIL mem_busy[%0d] stall=%b flush=%b exp 11111/00000", i, stall, flush); end
         tick();
         scModel++;
      end
      mem_busy = 1'b0;
      #1;
      checks++; if (stall_cnt !== expSc()) begin failures++; $display("FAIL sat sc=%0d exp %0d", stall_cnt, expSc()); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_redirect();
      test_mc();
      test_mc_short();
      test_reset_mid_mc();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
Parametrised global stall/flush controller for the N-stage in-order pipeline. It replaces the hard-wired per-stage stall/flush equations in the core top level. It arbitrates external memory stall, multicycle-execute occupancy, branch/jump redirect and load-use interlock into per-stage stall and flush vectors. It also sequences a post-reset pipeline flush and keeps hazard performance counters. Stage index 0 is fetch; higher indices are older stages.

Parameters:
NUM_STAGES, 5, pipeline stage count (>=3).
REDIRECT_STAGE, 2, stage resolving branches/jumps (1..NUM_STAGES-2).
LOADUSE_STAGE, 2, stage receiving the load-use bubble (1..NUM_STAGES-2).
MC_STAGE, 2, stage hosting multicycle ops (1..NUM_STAGES-2).
MC_CYC_W, 6, width of the multicycle length field.
RST_FLUSH_CYC, 2, flush cycles after reset release (>=1).
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mem_busy  in  1  memory not ready; freezes the whole pipe.
redirect_req  in  1  taken branch/jump at REDIRECT_STAGE; held by source while stalled.
lw_hazard  in  1  load-use detected; consumer is in stage LOADUSE_STAGE-1.
mc_start  in  1  multicycle op entering MC_STAGE this cycle.
mc_cycles  in  MC_CYC_W  total occupancy of that op, in cycles.
stall  out  NUM_STAGES  per-stage hold enable.
flush  out  NUM_STAGES  per-stage bubble insert (clears the stage's valid).
mc_busy  out  1  multicycle occupancy active.
stall_cnt  out  CNT_W  cycles with stall[0]=1 (performance).
redirect_cnt  out  CNT_W  accepted redirects (performance).

Behaviour:
- States: RST_FLUSH, RUN, MC_WAIT. Registered down-counter cnt of width max(MC_CYC_W, clog2(RST_FLUSH_CYC+1)).
- Reset asserted, at any time including mid-MC_WAIT: state=RST_FLUSH, cnt=RST_FLUSH_CYC, counters=0. Outputs during reset: flush=all ones, stall=0, mc_busy=0.
- RST_FLUSH: flush=all ones, stall=0, all inputs ignored. cnt decrements each cycle; on reaching 1, go to RUN. Exactly RST_FLUSH_CYC flush cycles follow reset release.
- stall/flush are combinational from state and inputs, applying within the same cycle. Priority in RUN/MC_WAIT, highest first:
  1. mem_busy: stall=all ones, flush=0. Counters and cnt hold, except stall_cnt increments.
  2. MC_WAIT, or RUN with mc_start && mc_cycles!=0: stall[0..MC_STAGE]=1, flush[MC_STAGE+1]=1, other bits 0, mc_busy=1.
  3. redirect_req: flush[1..REDIRECT_STAGE-1]=1, stall=0, redirect_cnt increments.
  4. lw_hazard: stall[0..LOADUSE_STAGE-1]=1, flush[LOADUSE_STAGE]=1.
  5. Otherwise stall=0, flush=0.
- Multicycle timing:
  - In RUN, mc_start with mc_cycles=N>0 (and no mem_busy) stalls the current cycle.
  - If N>1: cnt=N-1, go to MC_WAIT. If N=1: stay in RUN.
  - MC_WAIT decrements cnt each cycle without mem_busy; leaves for RUN on the cycle cnt==1. Total stall cycles = N plus mem_busy cycles.
  - mc_cycles=0 is ignored: the op is treated as single-cycle.
- In MC_WAIT, mc_start, redirect_req and lw_hazard are ignored. A held redirect is honoured the cycle after return to RUN.
- redirect beats lw_hazard because the load-use consumer is wrong-path and is flushed.
- Counters saturate at all ones and never wrap.

Optional Feature:
PIPE_HAZARD_CTL_PERF_EN: when defined, stall_cnt and redirect_cnt are implemented as described. When undefined, both ports are tied to 0, no counter flops exist, and stall/flush behaviour is identical.

Test Plan:
- Release reset with RST_FLUSH_CYC=2 -> flush=5'b11111 for exactly 2 cycles, then 5'b00000 with stall=0.
- RUN, lw_hazard=1 for one cycle -> stall=5'b00011, flush=5'b00100 that cycle only.
- redirect_req=1 and lw_hazard=1 together -> flush=5'b00010, stall=0, redirect_cnt 0->1.
- mc_start, mc_cycles=4, with mem_busy=1 on the 2nd MC_WAIT cycle -> stall=5'b00111 and flush=5'b01000 for 4 MC cycles plus 1 cycle of stall=5'b11111 (flush=0). mc_busy high throughout the 5 cycles; RUN on cycle 6.
- Reset asserted during MC_WAIT (cnt=3) -> immediately flush=all ones, mc_busy=0, state RST_FLUSH; counters cleared.
- With CNT_W=4 and PIPE_HAZARD_CTL_PERF_EN, 20 mem_busy cycles -> stall_cnt saturates at 15. Without the macro, stall_cnt stays 0.
